// File: rtl/vpu_mem_pkg.sv
// Shared definitions for the video object memory path: record geometry,
// arbiter state encoding and the read-owner tag carried alongside reads.
package vpu_mem_pkg;

    localparam int OBJ_ADDR_W = 5;
    localparam int OBJ_DATA_W = 144;

    typedef enum logic {
        ARB_ST    = 1'b0,
        LOCKED_ST = 1'b1
    } arb_state_e;

    // Owner of an in-flight read; is_clip=0 means the matrix unit issued it.
    typedef struct packed {
        logic valid;
        logic is_clip;
    } rd_tag_t;

    localparam rd_tag_t TAG_IDLE = '{valid: 1'b0, is_clip: 1'b0};

endpackage

// File: rtl/obj_mem_rd_tag_pipe.sv
// Delay line that tracks which requester owns each outstanding memory read.
// The tag pops out in the same cycle the memory presents the read data.
module obj_mem_rd_tag_pipe
    import vpu_mem_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t push_tag,
    output rd_tag_t pop_tag
);

    rd_tag_t stage [RD_LAT];

    // Shift tags one stage per cycle; reset drops every in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage[i] <= TAG_IDLE;
            end
        end else begin
            stage[0] <= push_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign pop_tag = stage[RD_LAT-1];

endmodule

// File: rtl/obj_mem_arbiter.sv
// Single-port object memory arbiter between the matrix unit (read/write,
// lockable for read-modify-write) and the clipping unit (reads only).
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ARB_ST    | normal arbitration; matrix preferred unless clipper starved
//   LOCKED_ST | matrix owns the memory until it issues an unlocked access
module obj_mem_arbiter
    import vpu_mem_pkg::*;
#(
    parameter int ADDR_W     = OBJ_ADDR_W,
    parameter int DATA_W     = OBJ_DATA_W,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mat_req,
    input  logic              mat_we,
    input  logic              mat_lock,
    input  logic [ADDR_W-1:0] mat_addr,
    input  logic [DATA_W-1:0] mat_wdata,
    output logic              mat_gnt,
    output logic              mat_rvld,
    output logic [DATA_W-1:0] mat_rdata,
    input  logic              clip_req,
    input  logic [ADDR_W-1:0] clip_addr,
    output logic              clip_gnt,
    output logic              clip_rvld,
    output logic [DATA_W-1:0] clip_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              locked
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arb_state_e        state, state_next;
    logic [CNT_W-1:0]  starve_cnt, starve_next;
    logic              clip_win, mat_win;
    rd_tag_t           push_tag, pop_tag;
    logic [DATA_W-1:0] mat_rdata_q, clip_rdata_q;

    // Pick at most one winner; the clipper only overtakes a pending matrix
    // request once the matrix has used up its starvation allowance.
    always_comb begin
        clip_win = 1'b0;
        mat_win  = 1'b0;
        if (!rst) begin
            if (state == ARB_ST && clip_req && (!mat_req || starve_cnt == CNT_MAX)) begin
                clip_win = 1'b1;
            end else if (mat_req) begin
                mat_win = 1'b1;
            end
        end
    end

    assign mat_gnt  = mat_win;
    assign clip_gnt = clip_win;
    assign locked   = (state == LOCKED_ST) && !rst;

    // Drive the memory port straight from the winner; idle cycles drive zeros.
    always_comb begin
        mem_en    = clip_win | mat_win;
        mem_we    = mat_win & mat_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (clip_win) begin
            mem_addr = clip_addr;
        end else if (mat_win) begin
            mem_addr = mat_addr;
            if (mat_we) begin
                mem_wdata = mat_wdata;
            end
        end
    end

    // Next state and starvation counter; the counter is frozen while locked
    // because the clipper cannot be served then anyway.
    always_comb begin
        state_next  = state;
        starve_next = starve_cnt;
        case (state)
            ARB_ST:    if (mat_win && mat_lock)  state_next = LOCKED_ST;
            LOCKED_ST: if (mat_win && !mat_lock) state_next = ARB_ST;
            default:   state_next = ARB_ST;
        endcase
        if (!clip_req || clip_win) begin
            starve_next = '0;
        end else if (state == ARB_ST && mat_win && starve_cnt != CNT_MAX) begin
            starve_next = starve_cnt + CNT_W'(1);
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_ST;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
        end
    end

    assign push_tag = '{valid: mem_en & ~mem_we, is_clip: clip_win};

    obj_mem_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk      (clk),
        .rst      (rst),
        .push_tag (push_tag),
        .pop_tag  (pop_tag)
    );

    assign mat_rvld  = pop_tag.valid & ~pop_tag.is_clip & ~rst;
    assign clip_rvld = pop_tag.valid &  pop_tag.is_clip & ~rst;

    // Read data passes through in the return cycle and is held afterwards.
    assign mat_rdata  = mat_rvld  ? mem_rdata : mat_rdata_q;
    assign clip_rdata = clip_rvld ? mem_rdata : clip_rdata_q;

    // Capture delivered read data so each side keeps its last result.
    always_ff @(posedge clk) begin
        if (rst) begin
            mat_rdata_q  <= '0;
            clip_rdata_q <= '0;
        end else begin
            if (mat_rvld)  mat_rdata_q  <= mem_rdata;
            if (clip_rvld) clip_rdata_q <= mem_rdata;
        end
    end

endmodule
